// File: rtl/riscv_irq_scheduler.sv
// Interrupt scheduler: synchronises sources, latches edge events into pending bits and presents
// the lowest-index enabled pending source as a stable one-hot request until the core acks it.
module riscv_irq_scheduler #(
    parameter int NUM_IRQ     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic [31:0]        irq_o,
    output logic [4:0]         irq_id_o,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_ack_id_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_e;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] s_d_q;
    logic [NUM_IRQ-1:0] rise_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] en_q;
    logic [NUM_IRQ-1:0] edge_q;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] id_hot;
    logic [NUM_IRQ-1:0] sw_set, sw_clr, ack_clr;
    logic [NUM_IRQ-1:0] wdata_lo;
    state_e             state_q, state_d;
    logic [4:0]         id_q, id_d;
    logic [4:0]         lo_idx;
    logic               ack_hit;
    logic               withdraw;
    logic               busy;

    assign s        = sync_q[SYNC_STAGES-1];
    assign wdata_lo = cfg_wdata_i[NUM_IRQ-1:0];
    assign cand     = pend_q & en_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        id_hot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            id_hot[i] = (id_q == 5'(i));
        end
    end

    always_comb begin
        lo_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                lo_idx = 5'(i);
            end
        end
    end

    assign ack_hit  = (state_q == REQ) && irq_ack_i && (irq_ack_id_i == id_q);
    // Software pulls the request back by disabling it or clearing its pending bit.
    assign withdraw = cfg_we_i && (((cfg_addr_i == 2'd0) && !cfg_wdata_i[id_q]) ||
                                   ((cfg_addr_i == 2'd3) &&  cfg_wdata_i[id_q]));

    assign sw_set  = (cfg_we_i && cfg_addr_i == 2'd2) ? wdata_lo : '0;
    assign sw_clr  = (cfg_we_i && cfg_addr_i == 2'd3) ? wdata_lo : '0;
    assign ack_clr = ack_hit ? id_hot : '0;

    // Set terms are OR-ed after the clear so a coincident event is never lost.
    assign pend_d = (edge_q & ((pend_q & ~(sw_clr | ack_clr)) | rise_q | sw_set)) |
                    (~edge_q & s);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = REQ;
                    id_d    = lo_idx;
                end
            end
            REQ: begin
                if (ack_hit || withdraw) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            s_d_q   <= '0;
            rise_q  <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            edge_q  <= '0;
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            sync_q[0] <= irq_src_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d_q   <= s;
            rise_q  <= s & ~s_d_q;
            pend_q  <= pend_d;
            state_q <= state_d;
            id_q    <= id_d;
            if (cfg_we_i && cfg_addr_i == 2'd0) begin
                en_q <= wdata_lo;
            end
            if (cfg_we_i && cfg_addr_i == 2'd1) begin
                edge_q <= wdata_lo;
            end
        end
    end

    // Request outputs come only from state_q/id_q, never from inputs.
    always_comb begin
        irq_o = '0;
        if (state_q == REQ) begin
            irq_o[id_q] = 1'b1;
        end
    end

    assign irq_id_o = id_q;

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            2'd0:    cfg_rdata_o[NUM_IRQ-1:0] = en_q;
            2'd1:    cfg_rdata_o[NUM_IRQ-1:0] = edge_q;
            2'd2:    cfg_rdata_o[NUM_IRQ-1:0] = pend_q;
            default: cfg_rdata_o = {23'b0, busy, 3'b0, id_q};
        endcase
    end

endmodule

// File: tb/tb_riscv_irq_scheduler.sv
// Bench for riscv_irq_scheduler: directed stimulus pushes expected presentations (vector, id,
// cycle) into a queue; a monitor pops one each time irq_o rises from zero.
module tb_riscv_irq_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] irq_src_i = '0;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_addr_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic [31:0] cfg_rdata_o;
    logic [31:0] irq_o;
    logic [4:0]  irq_id_o;
    logic        irq_ack_i = 1'b0;
    logic [4:0]  irq_ack_id_i = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] vec;
        logic [4:0]  id;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    riscv_irq_scheduler #(.NUM_IRQ(32), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src_i    (irq_src_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o),
        .irq_ack_i    (irq_ack_i),
        .irq_ack_id_i (irq_ack_id_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] vec, input logic [4:0] id, input int c);
        exp_t e;
        e.vec = vec;
        e.id  = id;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        step(1);
        cfg_we_i    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_addr_i = a;
        #1;
        d = cfg_rdata_o;
    endtask

    task automatic ack(input logic [4:0] id);
        irq_ack_i    = 1'b1;
        irq_ack_id_i = id;
        step(1);
        irq_ack_i    = 1'b0;
    endtask

    // Monitor: each new presentation must match the head of the queue, including its cycle.
    initial begin : monitor
        logic [31:0] prev;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (irq_o != 0 && prev == 0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req irq_o=%h id=%0d cyc=%0d", irq_o, irq_id_o, cyc);
                end else begin
                    e = sb.pop_front();
                    if (irq_o !== e.vec || irq_id_o !== e.id || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL presentation actual irq_o=%h id=%0d cyc=%0d required irq_o=%h id=%0d cyc=%0d",
                                 irq_o, irq_id_o, cyc, e.vec, e.id, e.cyc);
                    end
                end
            end else if (irq_o != 0 && prev != 0) begin
                checks++;
                if (irq_o !== prev) begin
                    errors++;
                    $display("FAIL req_stable actual=%h required=%h", irq_o, prev);
                end
            end
            prev = irq_o;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] d;
        int          e;
        int          a;
        int          w;

        step(2);
        chk("rst_irq_o", irq_o, 32'h0);
        chk("rst_irq_id", {27'b0, irq_id_o}, 32'h0);
        rst_n = 1'b1;
        step(1);
        for (int i = 0; i < 4; i++) begin
            rd(i[1:0], d);
            chk("rst_rdata", d, 32'h0);
        end

        cfg_wr(2'd1, 32'h0000_047F);
        cfg_wr(2'd0, 32'h0000_04FF);
        rd(2'd1, d);
        chk("edge_reg", d, 32'h0000_047F);

        // Edge source 3, three-cycle pulse.
        e = cyc;
        irq_src_i[3] = 1'b1;
        push(32'h8, 5'd3, e + 5);
        step(3);
        irq_src_i[3] = 1'b0;
        step(2);
        rd(2'd3, d);
        chk("status_req3", d, 32'h0000_0103);
        ack(5'd3);
        chk("gap_a0", irq_o, 32'h0);
        rd(2'd3, d);
        chk("status_gap", d, 32'h0000_0103);
        step(1);
        chk("gap_a1", irq_o, 32'h0);
        rd(2'd3, d);
        chk("status_idle", d, 32'h0000_0003);
        rd(2'd2, d);
        chk("pend3_clr", d, 32'h0);

        // Sources 5 and 2 together; 0 arrives during REQ(5) and must wait.
        e = cyc;
        irq_src_i[5] = 1'b1;
        irq_src_i[2] = 1'b1;
        push(32'h4, 5'd2, e + 5);
        step(5);
        irq_src_i[5] = 1'b0;
        irq_src_i[2] = 1'b0;
        a = cyc + 1;
        push(32'h20, 5'd5, a + 2);
        ack(5'd2);
        step(2);
        irq_src_i[0] = 1'b1;
        step(7);
        chk("no_preempt", irq_o, 32'h20);
        irq_src_i[0] = 1'b0;
        a = cyc + 1;
        push(32'h1, 5'd0, a + 2);
        ack(5'd5);
        step(2);
        ack(5'd0);
        step(2);
        rd(2'd2, d);
        chk("pend_all_clr", d, 32'h0);

        // Level source 7 drops before the ack.
        e = cyc;
        irq_src_i[7] = 1'b1;
        push(32'h80, 5'd7, e + 4);
        step(4);
        irq_src_i[7] = 1'b0;
        step(5);
        chk("level_hold", irq_o, 32'h80);
        ack(5'd7);
        chk("level_gap", irq_o, 32'h0);
        step(5);
        chk("level_no_rereq", irq_o, 32'h0);
        rd(2'd2, d);
        chk("level_pend", d, 32'h0);

        // REQ(4) by software set, wrong-id ack, then withdraw via ENABLE.
        w = cyc + 1;
        push(32'h10, 5'd4, w + 1);
        cfg_wr(2'd2, 32'h10);
        step(1);
        ack(5'd9);
        chk("bad_ack_ignored", irq_o, 32'h10);
        rd(2'd3, d);
        chk("status_req4", d, 32'h0000_0104);
        cfg_wr(2'd0, 32'h0000_04EF);
        chk("withdraw_gap", irq_o, 32'h0);
        step(4);
        chk("withdraw_idle", irq_o, 32'h0);
        rd(2'd2, d);
        chk("withdraw_pend", d, 32'h10);
        cfg_wr(2'd3, 32'h10);
        cfg_wr(2'd0, 32'h0000_04FF);
        rd(2'd2, d);
        chk("sw_clear", d, 32'h0);

        // Edge source 1: ack coincides with a new rising edge.
        e = cyc;
        irq_src_i[1] = 1'b1;
        push(32'h2, 5'd1, e + 5);
        step(2);
        irq_src_i[1] = 1'b0;
        step(3);
        irq_src_i[1] = 1'b1;
        step(3);
        a = cyc + 1;
        push(32'h2, 5'd1, a + 2);
        ack(5'd1);
        chk("coincide_gap", irq_o, 32'h0);
        step(2);
        irq_src_i[1] = 1'b0;
        ack(5'd1);
        step(2);

        // Software set of edge source 10.
        w = cyc + 1;
        push(32'h400, 5'd10, w + 1);
        cfg_wr(2'd2, 32'h400);
        rd(2'd2, d);
        chk("swset_pend", d, 32'h400);
        step(1);
        chk("swset_req", irq_o, 32'h400);
        ack(5'd10);
        step(2);

        // Reset asserted during REQ(6).
        e = cyc;
        irq_src_i[6] = 1'b1;
        push(32'h40, 5'd6, e + 5);
        step(6);
        rst_n = 1'b0;
        #1;
        chk("arst_irq_o", irq_o, 32'h0);
        chk("arst_irq_id", {27'b0, irq_id_o}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(i[1:0], d);
            chk("arst_rdata", d, 32'h0);
        end
        irq_src_i[6] = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(8);
        chk("post_rst_irq", irq_o, 32'h0);
        rd(2'd2, d);
        chk("post_rst_pend", d, 32'h0);
        rd(2'd0, d);
        chk("post_rst_en", d, 32'h0);

        step(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL queue_leftover actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
